// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory port arbiter
// Purpose: FSM state encoding, owner IDs and default bus/timeout parameters.
// Ports: none (package).
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   localparam int DEF_AW      = 32;
   localparam int DEF_DW      = 32;
   localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory bus signals of the arbiter
// Purpose: bundles the fetch requester, data requester and memory bus signals.
// Ports (slave = arbiter side):
//   in : if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ack
//   out: if_rdata, if_mfc, d_rdata, d_mfc, mem_req, mem_we, mem_addr,
//        mem_wdata, mem_be, err, busy
// The master modport is the mirror image, used by requesters / bus models.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
);

   logic              if_req;
   logic [AW-1:0]     if_addr;
   logic [DW-1:0]     if_rdata;
   logic              if_mfc;

   logic              d_req;
   logic              d_we;
   logic [AW-1:0]     d_addr;
   logic [DW-1:0]     d_wdata;
   logic [DW/8-1:0]   d_be;
   logic [DW-1:0]     d_rdata;
   logic              d_mfc;

   logic              mem_req;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW/8-1:0]   mem_be;
   logic [DW-1:0]     mem_rdata;
   logic              mem_ack;

   logic              err;
   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
      input  mem_rdata, mem_ack,
      output if_rdata, if_mfc, d_rdata, d_mfc,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be, err, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
      output mem_rdata, mem_ack,
      input  if_rdata, if_mfc, d_rdata, d_mfc,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, err, busy
   );

endinterface

// File: rtl/bus_timeout_ctr.sv
// rtl/bus_timeout_ctr.sv - saturating GRANT-cycle counter for bus timeout
// Purpose: counts GRANT cycles; flags the last GRANT cycle allowed before abort.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clr     in  clear count to 0
//   en      in  count this cycle (saturates at TIMEOUT, never wraps)
//   expired out current cycle is GRANT cycle number TIMEOUT (abort at its end)
module bus_timeout_ctr #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int            CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (en && (r_cnt != MAX)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Count starts at 0 in the first GRANT cycle, so reaching TIMEOUT-1 means
   // this is the TIMEOUT-th cycle; the counter lands on TIMEOUT at its end.
   assign expired = (r_cnt >= LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter for fetch and load/store
// Purpose: grants the memory bus to fetch or data path (round-robin on ties),
// holds the access until mem_ack or timeout, then pulses the owner's MFC.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of mem_port_arbiter_if (requesters + memory bus)
// All outputs are registered.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = DEF_AW,
   parameter int DW      = DEF_DW,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input logic                 clk,
   input logic                 rst,
   mem_port_arbiter_if.slave   bus
);

   state_t            r_state,     w_state_nxt;
   logic              r_gnt_d,     w_gnt_nxt;
   logic              r_last_d,    w_last_nxt;
   logic              r_mem_req,   w_mem_req_nxt;
   logic              r_mem_we,    w_mem_we_nxt;
   logic [AW-1:0]     r_mem_addr,  w_mem_addr_nxt;
   logic [DW-1:0]     r_mem_wdata, w_mem_wdata_nxt;
   logic [DW/8-1:0]   r_mem_be,    w_mem_be_nxt;
   logic [DW-1:0]     r_if_rdata,  w_if_rdata_nxt;
   logic [DW-1:0]     r_d_rdata,   w_d_rdata_nxt;
   logic              r_if_mfc,    w_if_mfc_nxt;
   logic              r_d_mfc,     w_d_mfc_nxt;
   logic              r_err,       w_err_nxt;
   logic              r_busy,      w_busy_nxt;
   logic              w_pick_d;
   logic              w_cnt_en;
   logic              w_cnt_clr;
   logic              w_expired;

   bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_cnt_clr),
      .en      (w_cnt_en),
      .expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_gnt_d     <= OWN_IF;
         r_last_d    <= OWN_D;    // first tie goes to fetch
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_if_mfc    <= 1'b0;
         r_d_mfc     <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_gnt_d     <= w_gnt_nxt;
         r_last_d    <= w_last_nxt;
         r_mem_req   <= w_mem_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_mem_be    <= w_mem_be_nxt;
         r_if_rdata  <= w_if_rdata_nxt;
         r_d_rdata   <= w_d_rdata_nxt;
         r_if_mfc    <= w_if_mfc_nxt;
         r_d_mfc     <= w_d_mfc_nxt;
         r_err       <= w_err_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_gnt_nxt       = r_gnt_d;
      w_last_nxt      = r_last_d;
      w_mem_req_nxt   = r_mem_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_mem_be_nxt    = r_mem_be;
      w_if_rdata_nxt  = r_if_rdata;
      w_d_rdata_nxt   = r_d_rdata;
      w_if_mfc_nxt    = 1'b0;
      w_d_mfc_nxt     = 1'b0;
      w_err_nxt       = 1'b0;
      w_busy_nxt      = r_busy;
      w_cnt_en        = 1'b0;
      w_cnt_clr       = 1'b0;
      // On a tie the previous loser wins; otherwise whoever is asking.
      w_pick_d        = (bus.if_req && bus.d_req) ? ~r_last_d : bus.d_req;

      case (r_state)
         IDLE: begin
            if (bus.if_req || bus.d_req) begin
               w_gnt_nxt     = w_pick_d;
               w_mem_req_nxt = 1'b1;
               w_busy_nxt    = 1'b1;
               w_state_nxt   = GRANT;
               if (w_pick_d == OWN_D) begin
                  w_mem_we_nxt    = bus.d_we;
                  w_mem_addr_nxt  = bus.d_addr;
                  w_mem_wdata_nxt = bus.d_wdata;
                  w_mem_be_nxt    = bus.d_be;
               end else begin
                  w_mem_we_nxt    = 1'b0;
                  w_mem_addr_nxt  = bus.if_addr;
                  w_mem_wdata_nxt = '0;
                  w_mem_be_nxt    = '1;
               end
            end
         end
         GRANT: begin
            w_cnt_en = 1'b1;
            // MFC/err are set on the way into DONE so they are high during DONE.
            if (bus.mem_ack || w_expired) begin
               w_mem_req_nxt = 1'b0;
               w_state_nxt   = DONE;
               w_err_nxt     = ~bus.mem_ack;
               if (r_gnt_d == OWN_D) begin
                  w_d_rdata_nxt = bus.mem_ack ? bus.mem_rdata : '0;
                  w_d_mfc_nxt   = 1'b1;
               end else begin
                  w_if_rdata_nxt = bus.mem_ack ? bus.mem_rdata : '0;
                  w_if_mfc_nxt   = 1'b1;
               end
            end
         end
         DONE: begin
            w_last_nxt  = r_gnt_d;
            w_cnt_clr   = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
         default: begin
            w_mem_req_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
            w_cnt_clr     = 1'b1;
            w_state_nxt   = IDLE;
         end
      endcase
   end

   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_be    = r_mem_be;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.d_rdata   = r_d_rdata;
   assign bus.if_mfc    = r_if_mfc;
   assign bus.d_mfc     = r_d_mfc;
   assign bus.err       = r_err;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   n;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".mem_req"},   bus.mem_req,   0);
      chk({tag, ".mem_we"},    bus.mem_we,    0);
      chk({tag, ".mem_addr"},  bus.mem_addr,  0);
      chk({tag, ".mem_wdata"}, bus.mem_wdata, 0);
      chk({tag, ".mem_be"},    bus.mem_be,    0);
      chk({tag, ".if_rdata"},  bus.if_rdata,  0);
      chk({tag, ".d_rdata"},   bus.d_rdata,   0);
      chk({tag, ".if_mfc"},    bus.if_mfc,    0);
      chk({tag, ".d_mfc"},     bus.d_mfc,     0);
      chk({tag, ".err"},       bus.err,       0);
      chk({tag, ".busy"},      bus.busy,      0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
      bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;
      bus.mem_rdata = 0; bus.mem_ack = 0;

      // reset state
      tick(); tick();
      chk_all_zero("reset");
      rst = 0;
      tick();

      // fetch only, ack two cycles after mem_req
      bus.if_req = 1; bus.if_addr = 32'h100;
      tick();
      chk("f.mem_req", bus.mem_req, 1);
      chk("f.mem_addr", bus.mem_addr, 32'h100);
      chk("f.mem_we", bus.mem_we, 0);
      chk("f.mem_be", bus.mem_be, 4'hF);
      chk("f.mem_wdata", bus.mem_wdata, 0);
      chk("f.busy", bus.busy, 1);
      tick();
      chk("f.mem_req_hold", bus.mem_req, 1);
      chk("f.no_mfc_yet", bus.if_mfc, 0);
      bus.mem_ack = 1; bus.mem_rdata = 32'h00A00093;
      tick();
      bus.mem_ack = 0; bus.if_req = 0;
      chk("f.if_mfc", bus.if_mfc, 1);
      chk("f.if_rdata", bus.if_rdata, 32'h00A00093);
      chk("f.d_mfc", bus.d_mfc, 0);
      chk("f.mem_req_drop", bus.mem_req, 0);
      chk("f.err", bus.err, 0);
      tick();
      chk("f.if_mfc_pulse", bus.if_mfc, 0);
      chk("f.busy_idle", bus.busy, 0);

      // store, zero-wait ack
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2004;
      bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'h3;
      tick();
      chk("s.mem_req", bus.mem_req, 1);
      chk("s.mem_we", bus.mem_we, 1);
      chk("s.mem_addr", bus.mem_addr, 32'h2004);
      chk("s.mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
      chk("s.mem_be", bus.mem_be, 4'h3);
      bus.mem_ack = 1; bus.mem_rdata = 32'h5A5A5A5A;
      tick();
      bus.mem_ack = 0; bus.d_req = 0; bus.d_we = 0;
      chk("s.d_mfc", bus.d_mfc, 1);
      chk("s.if_mfc", bus.if_mfc, 0);
      chk("s.if_rdata_hold", bus.if_rdata, 32'h00A00093);
      tick();
      chk("s.d_mfc_pulse", bus.d_mfc, 0);

      // tie from reset: fetch first, then data
      rst = 1; tick(); rst = 0;
      bus.if_req = 1; bus.if_addr = 32'h300;
      bus.d_req = 1; bus.d_addr = 32'h400; bus.d_be = 4'hF;
      tick();
      chk("t1.first_fetch", bus.mem_addr, 32'h300);
      chk("t1.first_we", bus.mem_we, 0);
      bus.mem_ack = 1; bus.mem_rdata = 32'h11111111;
      tick();
      bus.mem_ack = 0; bus.if_req = 0;
      chk("t1.if_mfc", bus.if_mfc, 1);
      chk("t1.d_mfc", bus.d_mfc, 0);
      tick();
      chk("t1.idle_gap", bus.mem_req, 0);
      tick();
      chk("t1.second_req", bus.mem_req, 1);
      chk("t1.second_data", bus.mem_addr, 32'h400);
      bus.mem_ack = 1; bus.mem_rdata = 32'h22222222;
      tick();
      bus.mem_ack = 0; bus.d_req = 0;
      chk("t1.d_mfc2", bus.d_mfc, 1);
      chk("t1.d_rdata", bus.d_rdata, 32'h22222222);
      chk("t1.if_rdata_hold", bus.if_rdata, 32'h11111111);
      tick();

      // single fetch to make last owner = fetch, then tie -> data wins
      bus.if_req = 1; bus.if_addr = 32'h500;
      tick();
      bus.mem_ack = 1; bus.mem_rdata = 32'h55555555;
      tick();
      bus.mem_ack = 0; bus.if_req = 0;
      tick();
      bus.if_req = 1; bus.if_addr = 32'h600;
      bus.d_req = 1; bus.d_addr = 32'h700;
      tick();
      chk("t2.data_wins", bus.mem_addr, 32'h700);
      bus.mem_ack = 1; bus.mem_rdata = 32'h77777777;
      tick();
      bus.mem_ack = 0; bus.d_req = 0;
      chk("t2.d_mfc", bus.d_mfc, 1);
      tick(); tick();
      chk("t2.fetch_next", bus.mem_addr, 32'h600);
      bus.mem_ack = 1; bus.mem_rdata = 32'h66666666;
      tick();
      bus.mem_ack = 0; bus.if_req = 0;
      chk("t2.if_rdata", bus.if_rdata, 32'h66666666);
      tick();

      // timeout on a data load
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h800;
      tick();
      n = 0;
      while (bus.mem_req && n < 40) begin
         n++;
         tick();
      end
      bus.d_req = 0;
      chk("to.req_cycles", n, 15);
      chk("to.d_mfc", bus.d_mfc, 1);
      chk("to.err", bus.err, 1);
      chk("to.d_rdata", bus.d_rdata, 0);
      tick();
      chk("to.err_pulse", bus.err, 0);
      bus.if_req = 1; bus.if_addr = 32'h880;
      tick();
      chk("to.next_grant", bus.mem_addr, 32'h880);
      bus.mem_ack = 1; bus.mem_rdata = 32'h88888888;
      tick();
      bus.mem_ack = 0; bus.if_req = 0;
      chk("to.next_mfc", bus.if_mfc, 1);
      chk("to.next_err", bus.err, 0);
      chk("to.next_rdata", bus.if_rdata, 32'h88888888);
      tick();

      // reset on the 3rd GRANT cycle, late ack afterwards
      bus.if_req = 1; bus.if_addr = 32'h900;
      tick(); tick(); tick();
      chk("rst.in_grant", bus.mem_req, 1);
      rst = 1; bus.if_req = 0;
      tick();
      rst = 0; bus.mem_ack = 1; bus.mem_rdata = 32'h99999999;
      chk_all_zero("rst");
      tick();
      bus.mem_ack = 0;
      chk("rst.late_ack_req", bus.mem_req, 0);
      chk("rst.late_ack_mfc", bus.if_mfc, 0);
      chk("rst.late_ack_rdata", bus.if_rdata, 0);
      tick();
      chk("rst.no_mfc_if", bus.if_mfc, 0);
      chk("rst.no_mfc_d", bus.d_mfc, 0);

      // back-to-back fetch: next mem_req two cycles after MFC
      bus.if_req = 1; bus.if_addr = 32'hA00;
      tick();
      bus.mem_ack = 1; bus.mem_rdata = 32'h33333333;
      tick();
      bus.mem_ack = 0; bus.if_addr = 32'hA04;
      chk("b2b.mfc1", bus.if_mfc, 1);
      tick();
      chk("b2b.gap", bus.mem_req, 0);
      tick();
      chk("b2b.req2", bus.mem_req, 1);
      chk("b2b.addr2", bus.mem_addr, 32'hA04);
      bus.mem_ack = 1; bus.mem_rdata = 32'h44444444;
      tick();
      bus.mem_ack = 0; bus.if_req = 0;
      chk("b2b.mfc2", bus.if_mfc, 1);
      chk("b2b.rdata2", bus.if_rdata, 32'h44444444);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
